// File: rtl/spectral_flux_onset_pkg.sv
// spectral_flux_onset_pkg: shared state type, default sizes and per-band bin edges for the onset detector.
package spectral_flux_onset_pkg;
   typedef enum logic {ACCUM, EMIT} state_t;
   localparam int NUM_BINS_D  = 64;
   localparam int MAG_W_D     = 16;
   localparam int FLUX_W_D    = 24;
   localparam int HIST_D      = 8;
   localparam int THR_SHIFT_D = 2;
   localparam int MIN_FLUX_D  = 16;
   localparam int REFRACT_D   = 4;
   localparam int BIN_AW_D    = $clog2(NUM_BINS_D);
   localparam int HIST_AW_D   = $clog2(HIST_D);
   localparam int LOW_LO  = 1;
   localparam int LOW_HI  = 8;
   localparam int MID_LO  = 9;
   localparam int MID_HI  = 24;
   localparam int HIGH_LO = 25;
   localparam int HIGH_HI = 63;
endpackage

// File: rtl/spectral_flux_onset_if.sv
// spectral_flux_onset_if: magnitude stream in, flux/beat result out.
//  master: upstream side, drives mag_valid/mag_in/mag_last, sees mag_ready and the results.
//  slave:  detector side, accepts samples, drives mag_ready/flux_valid/flux_out/beat_valid.
interface spectral_flux_onset_if
   import spectral_flux_onset_pkg::*;
#(
   parameter int MAG_W  = MAG_W_D,
   parameter int FLUX_W = FLUX_W_D
);
   logic              mag_valid;
   logic [MAG_W-1:0]  mag_in;
   logic              mag_last;
   logic              mag_ready;
   logic              flux_valid;
   logic [FLUX_W-1:0] flux_out;
   logic              beat_valid;
   modport master (output mag_valid, mag_in, mag_last, input mag_ready, flux_valid, flux_out, beat_valid);
   modport slave  (input mag_valid, mag_in, mag_last, output mag_ready, flux_valid, flux_out, beat_valid);
endinterface

// File: rtl/spectral_flux_onset_flux_threshold.sv
// spectral_flux_onset_flux_threshold: adaptive moving-average beat decision over the last HIST frame fluxes.
//  clk, rst  clock, synchronous active-high reset
//  flux_i    flux of the frame being emitted
//  push_i    frame is being emitted this cycle
//  primed_i  frame is a primed one (history/counters only advance on primed frames)
//  beat_o    beat decision for flux_i against the history before this frame
module spectral_flux_onset_flux_threshold
   import spectral_flux_onset_pkg::*;
#(
   parameter int FLUX_W    = FLUX_W_D,
   parameter int HIST      = HIST_D,
   parameter int THR_SHIFT = THR_SHIFT_D,
   parameter int MIN_FLUX  = MIN_FLUX_D,
   parameter int REFRACT   = REFRACT_D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLUX_W-1:0] flux_i,
   input  logic              push_i,
   input  logic              primed_i,
   output logic              beat_o
);
   localparam int HW = $clog2(HIST);
   localparam int SW = FLUX_W + HW;
   localparam int NW = $clog2(HIST + 1);
   localparam int RW = $clog2(REFRACT + 1);
   logic [FLUX_W-1:0] hist_q [HIST];
   logic [SW-1:0]     sum_q;
   logic [NW-1:0]     nfr_q;
   logic [RW-1:0]     refr_q;
   logic [FLUX_W-1:0] mean;
   logic [FLUX_W:0]   thr;
   assign mean   = sum_q[SW-1:HW];
   assign thr    = {1'b0, mean} + {1'b0, mean >> THR_SHIFT};
   assign beat_o = primed_i && flux_i >= FLUX_W'(MIN_FLUX) && {1'b0, flux_i} > thr &&
                   refr_q == '0 && nfr_q == NW'(HIST);
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < HIST; i++) hist_q[i] <= '0;
         sum_q  <= '0;
         nfr_q  <= '0;
         refr_q <= '0;
      end else if (push_i && primed_i) begin
         hist_q[0] <= flux_i;
         for (int i = 1; i < HIST; i++) hist_q[i] <= hist_q[i-1];
         // history starts zeroed, so subtracting the oldest entry is valid from the first push
         sum_q  <= sum_q + SW'(flux_i) - SW'(hist_q[HIST-1]);
         nfr_q  <= nfr_q == NW'(HIST) ? nfr_q : nfr_q + 1'b1;
         refr_q <= beat_o ? RW'(REFRACT) : (refr_q != '0 ? refr_q - 1'b1 : refr_q);
      end
   end
endmodule

// File: rtl/spectral_flux_onset.sv
// spectral_flux_onset: half-wave-rectified spectral flux over a bin band, one flux per frame, adaptive beat flag.
//  clk, reset  clock, synchronous active-high reset
//  s           slave side of spectral_flux_onset_if: magnitude stream in, flux_valid/flux_out/beat_valid out
module spectral_flux_onset
   import spectral_flux_onset_pkg::*;
#(
   parameter int NUM_BINS  = NUM_BINS_D,
   parameter int MAG_W     = MAG_W_D,
   parameter int FLUX_W    = FLUX_W_D,
   parameter int BAND_LO   = LOW_LO,
   parameter int BAND_HI   = LOW_HI,
   parameter int HIST      = HIST_D,
   parameter int THR_SHIFT = THR_SHIFT_D,
   parameter int MIN_FLUX  = MIN_FLUX_D,
   parameter int REFRACT   = REFRACT_D
) (
   input logic clk,
   input logic reset,
   spectral_flux_onset_if.slave s
);
   localparam int KW = $clog2(NUM_BINS);
   state_t            state_q;
   logic [KW-1:0]     k_q;
   logic [FLUX_W-1:0] acc_q, acc_d, flux_out_q;
   logic              primed_q, flux_valid_q, beat_q;
   logic [MAG_W-1:0]  prev_q [NUM_BINS];
   logic [MAG_W-1:0]  prev_rd, diff;
   logic [FLUX_W:0]   acc_sum;
   logic              take, in_band, beat;
   assign take    = s.mag_valid && state_q == ACCUM;
   assign prev_rd = prev_q[k_q];
   assign diff    = s.mag_in > prev_rd ? s.mag_in - prev_rd : '0;
   assign in_band = k_q >= KW'(BAND_LO) && k_q <= KW'(BAND_HI);
   always_comb begin
      acc_sum = {1'b0, acc_q} + (in_band ? (FLUX_W+1)'(diff) : '0);
      acc_d   = acc_sum[FLUX_W] ? '1 : acc_sum[FLUX_W-1:0];
   end
   // prev RAM is left uncleared on reset; the primed flag masks stale contents
   always_ff @(posedge clk) begin
      if (take && !reset) prev_q[k_q] <= s.mag_in;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ACCUM;
         k_q          <= '0;
         acc_q        <= '0;
         primed_q     <= 1'b0;
         flux_out_q   <= '0;
         flux_valid_q <= 1'b0;
         beat_q       <= 1'b0;
      end else begin
         flux_valid_q <= state_q == EMIT;
         beat_q       <= state_q == EMIT && beat;
         if (state_q == EMIT) begin
            flux_out_q <= primed_q ? acc_q : '0;
            primed_q   <= 1'b1;
            acc_q      <= '0;
            state_q    <= ACCUM;
         end else if (take) begin
            acc_q <= acc_d;
            // bin index sticks at the last bin so overlong frames keep overwriting it
            k_q   <= s.mag_last ? '0 : (k_q == KW'(NUM_BINS-1) ? k_q : k_q + 1'b1);
            if (s.mag_last) state_q <= EMIT;
         end
      end
   end
   spectral_flux_onset_flux_threshold #(
      .FLUX_W(FLUX_W), .HIST(HIST), .THR_SHIFT(THR_SHIFT), .MIN_FLUX(MIN_FLUX), .REFRACT(REFRACT)
   ) u_thr (
      .clk(clk), .rst(reset), .flux_i(acc_q), .push_i(state_q == EMIT), .primed_i(primed_q), .beat_o(beat)
   );
   assign s.mag_ready  = state_q == ACCUM;
   assign s.flux_valid = flux_valid_q;
   assign s.flux_out   = flux_out_q;
   assign s.beat_valid = beat_q;
endmodule

// File: tb/tb_spectral_flux_onset.sv
// tb_spectral_flux_onset: directed and random frames checked against a frame-level flux/threshold model.
module tb_spectral_flux_onset;
   localparam int NB = 64, MW = 16, FW = 16, LO = 1, HI = 8, H = 8, TS = 2, MF = 16, RF = 4;
   localparam int FMAX = (1 << FW) - 1;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   spectral_flux_onset_if #(.MAG_W(MW), .FLUX_W(FW)) bus();
   spectral_flux_onset #(
      .NUM_BINS(NB), .MAG_W(MW), .FLUX_W(FW), .BAND_LO(LO), .BAND_HI(HI),
      .HIST(H), .THR_SHIFT(TS), .MIN_FLUX(MF), .REFRACT(RF)
   ) dut (.clk(clk), .reset(reset), .s(bus));
   int total = 0, bad = 0;
   int fb [128];
   int prev_m [NB];
   int hist_m [H];
   bit primed_m;
   int nfr_m, refr_m, last_flux;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic fill(input int band_v, input int other_v);
      for (int i = 0; i < 128; i++) fb[i] = (i >= LO && i <= HI) ? band_v : other_v;
   endtask
   task automatic model_reset();
      primed_m = 0;
      nfr_m = 0;
      refr_m = 0;
      for (int i = 0; i < H; i++) hist_m[i] = 0;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      bus.mag_valid = 1'b0;
      bus.mag_last = 1'b0;
      step();
      reset = 1'b0;
      model_reset();
      last_flux = 0;
      chk("rst_ready", bus.mag_ready, 1);
      chk("rst_fvalid", bus.flux_valid, 0);
      chk("rst_flux", bus.flux_out, 0);
      chk("rst_beat", bus.beat_valid, 0);
   endtask
   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         bus.mag_valid = 1'b0;
         step();
         chk("idle_fvalid", bus.flux_valid, 0);
         chk("idle_hold", bus.flux_out, last_flux);
         chk("idle_beat", bus.beat_valid, 0);
      end
   endtask
   // sends fb[0..n-1] as one frame; exp_f/exp_b < 0 means only the model is consulted
   task automatic send(input int n, input int exp_f, input int exp_b);
      int acc, k, d, flux, sum, mean;
      bit b;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         chk("ready_accum", bus.mag_ready, 1);
         bus.mag_valid = 1'b1;
         bus.mag_in = MW'(fb[i]);
         bus.mag_last = (i == n - 1);
         k = i < NB ? i : NB - 1;
         d = fb[i] > prev_m[k] ? fb[i] - prev_m[k] : 0;
         if (k >= LO && k <= HI) acc = acc + d > FMAX ? FMAX : acc + d;
         prev_m[k] = fb[i];
         step();
      end
      bus.mag_valid = 1'($urandom_range(0, 1));
      bus.mag_last = 1'($urandom_range(0, 1));
      bus.mag_in = MW'($urandom);
      chk("ready_emit", bus.mag_ready, 0);
      chk("fvalid_early", bus.flux_valid, 0);
      if (!primed_m) begin
         flux = 0;
         b = 0;
         primed_m = 1;
      end else begin
         flux = acc;
         sum = 0;
         for (int i = 0; i < H; i++) sum += hist_m[i];
         mean = sum / H;
         b = flux >= MF && flux > mean + mean / (1 << TS) && refr_m == 0 && nfr_m >= H;
         for (int i = H - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
         hist_m[0] = flux;
         if (nfr_m < H) nfr_m++;
         refr_m = b ? RF : (refr_m > 0 ? refr_m - 1 : 0);
      end
      step();
      bus.mag_valid = 1'b0;
      bus.mag_last = 1'b0;
      chk("fvalid", bus.flux_valid, 1);
      chk("ready_back", bus.mag_ready, 1);
      chk("flux_model", bus.flux_out, flux);
      chk("beat_model", bus.beat_valid, b);
      if (exp_f >= 0) chk("flux_const", bus.flux_out, exp_f);
      if (exp_b >= 0) chk("beat_const", bus.beat_valid, exp_b);
      last_flux = flux;
   endtask
   initial begin
      bus.mag_valid = 1'b0;
      bus.mag_in = '0;
      bus.mag_last = 1'b0;
      for (int i = 0; i < NB; i++) prev_m[i] = 0;
      step();
      do_reset();
      // constant frames: unprimed then zero flux
      fill(100, 100); send(NB, 0, 0);
      idle(2);
      fill(100, 100); send(NB, 0, 0);
      // only band bins count
      fill(0, 0); send(NB, 0, 0);
      fill(50, 999); send(NB, 400, 0);
      // fill history with alternating 0/80 flux, then a large rise beats
      for (int f = 0; f < 8; f++) begin
         if (f % 2 == 0) fill(10, 10); else fill(20, 10);
         send(NB, f % 2 == 0 ? 0 : 80, 0);
      end
      fill(1000, 10); send(NB, 7840, 1);
      for (int f = 2; f <= 5; f++) begin
         fill(f * 1000, 10); send(NB, 8000, 0);
      end
      fill(6000, 10); send(NB, 8000, 1);
      // MIN_FLUX floor above an all-zero history
      for (int f = 0; f < 9; f++) begin
         fill(0, 0); send(NB, 0, 0);
      end
      fill(0, 0); fb[1] = 14; send(NB, 14, 0);
      fill(0, 0); send(NB, 0, 0);
      fill(0, 0); fb[1] = 16; send(NB, 16, 1);
      // saturation
      fill(0, 0); send(NB, 0, 0);
      fill(65535, 0); send(NB, FMAX, -1);
      // 1-bin frame (bin 0 is out of band) and an overlong frame
      fb[0] = 777; send(1, 0, -1);
      for (int i = 0; i < 70; i++) fb[i] = int'($urandom_range(0, 500));
      send(70, -1, -1);
      // reset mid-frame at bin 5
      for (int i = 0; i < 6; i++) begin
         bus.mag_valid = 1'b1;
         bus.mag_in = MW'($urandom_range(0, 400));
         bus.mag_last = 1'b0;
         prev_m[i] = int'(bus.mag_in);
         step();
      end
      do_reset();
      idle(4);
      for (int i = 0; i < NB; i++) fb[i] = int'($urandom_range(0, 400));
      send(NB, 0, 0);
      // random frames with random gaps
      for (int f = 0; f < 40; f++) begin
         int r, n, hi;
         r = int'($urandom_range(0, 9));
         n = r == 0 ? 1 : (r == 1 ? 66 + int'($urandom_range(0, 5)) : NB);
         hi = (f % 5 == 4) ? 3000 : 120;
         for (int i = 0; i < n; i++) fb[i] = int'($urandom_range(0, hi));
         send(n, -1, -1);
         idle(int'($urandom_range(0, 2)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
